// File: rtl/change_dispenser.sv
// Coin-return controller: pays a refund greedily in Rs. 10 / Rs. 5 coins through
// a hopper with per-coin acknowledge, tracking inventory and hopper timeouts.
module change_dispenser #(
    parameter int COIN5_INIT  = 8,
    parameter int COIN10_INIT = 8,
    parameter int CNT_W       = 8,
    parameter int AMT_W       = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             drop5,
    output logic             drop10,
    input  logic             hop_done,
    input  logic             refill5,
    input  logic             refill10,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] paid_units,
    output logic             fault,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt10
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_DROP   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]       state_r;
    logic [AMT_W-1:0] remaining_r;
    logic [AMT_W-1:0] paid_r;
    logic             coin10_r;
    logic [TW-1:0]    timer_r;
    logic [CNT_W-1:0] cnt5_r;
    logic [CNT_W-1:0] cnt10_r;
    logic [CNT_W-1:0] cnt5_s;
    logic [CNT_W-1:0] cnt10_s;
    logic             dec5_s;
    logic             dec10_s;

    // A simultaneous refill and eject cancel; refill alone saturates at full scale.
    function automatic logic [CNT_W-1:0] inv_step(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        if (inc && dec) begin
            nxt = cnt;
        end else if (inc) begin
            nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else if (dec) begin
            nxt = cnt - CNT_W'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Next inventory values from refills and the eject of the current DROP cycle.
    always_comb begin
        dec5_s  = (state_r == S_DROP) && !coin10_r;
        dec10_s = (state_r == S_DROP) && coin10_r;
        cnt5_s  = inv_step(cnt5_r, refill5, dec5_s);
        cnt10_s = inv_step(cnt10_r, refill10, dec10_s);
    end

    // Inventory registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt5_r  <= CNT_W'(COIN5_INIT);
            cnt10_r <= CNT_W'(COIN10_INIT);
        end else begin
            cnt5_r  <= cnt5_s;
            cnt10_r <= cnt10_s;
        end
    end

    // Payout state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            remaining_r <= {AMT_W{1'b0}};
            paid_r      <= {AMT_W{1'b0}};
            coin10_r    <= 1'b0;
            timer_r     <= {TW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        remaining_r <= req_amount;
                        paid_r      <= {AMT_W{1'b0}};
                        state_r     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (remaining_r >= AMT_W'(2) && cnt10_r != {CNT_W{1'b0}}) begin
                        coin10_r <= 1'b1;
                        state_r  <= S_DROP;
                    end else if (remaining_r >= AMT_W'(1) && cnt5_r != {CNT_W{1'b0}}) begin
                        coin10_r <= 1'b0;
                        state_r  <= S_DROP;
                    end else begin
                        state_r <= S_FINISH;
                    end
                end
                S_DROP: begin
                    timer_r <= {TW{1'b0}};
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    // The coin is credited only once the hopper confirms it left.
                    if (hop_done) begin
                        if (coin10_r) begin
                            remaining_r <= remaining_r - AMT_W'(2);
                            paid_r      <= paid_r + AMT_W'(2);
                        end else begin
                            remaining_r <= remaining_r - AMT_W'(1);
                            paid_r      <= paid_r + AMT_W'(1);
                        end
                        state_r <= S_SELECT;
                    end else if (timer_r == T_LAST) begin
                        state_r <= S_FAULT;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_FINISH: state_r <= S_IDLE;
                S_FAULT:  state_r <= S_FAULT;
                default:  state_r <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_r == S_IDLE);
    assign drop5      = (state_r == S_DROP) && !coin10_r;
    assign drop10     = (state_r == S_DROP) && coin10_r;
    assign done       = (state_r == S_FINISH);
    assign short      = (state_r == S_FINISH) && (remaining_r != {AMT_W{1'b0}});
    assign fault      = (state_r == S_FAULT);
    assign paid_units = paid_r;
    assign cnt5       = cnt5_r;
    assign cnt10      = cnt10_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected drops/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_amount = 4'd0;
    logic       req_ready, drop5, drop10, done, short, fault;
    logic       hop_done = 1'b1;
    logic       refill5 = 1'b0;
    logic       refill10 = 1'b0;
    logic [3:0] paid_units;
    logic [7:0] cnt5, cnt10;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int cyc; bit is10; } drop_t;
    typedef struct { int cyc; bit sh; int paid; int c5; int c10; } done_t;
    drop_t drop_q[$];
    done_t done_q[$];

    change_dispenser dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .drop5(drop5), .drop10(drop10), .hop_done(hop_done),
        .refill5(refill5), .refill10(refill10), .done(done), .short(short),
        .paid_units(paid_units), .fault(fault), .cnt5(cnt5), .cnt10(cnt10)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every drop and done pulse must match the head of its queue.
    initial begin
        drop_t d;
        done_t e;
        forever begin
            @(negedge clk);
            if (drop5 || drop10) begin
                if (drop_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_drop: drop5=%0d drop10=%0d, expected none (cycle %0d)",
                             drop5, drop10, cyc);
                end else begin
                    d = drop_q.pop_front();
                    chk("drop_cycle", cyc, d.cyc);
                    chk("drop_is10", int'(drop10), int'(d.is10));
                    chk("drop_exclusive", int'(drop5 & drop10), 0);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_short", int'(short), int'(e.sh));
                    chk("done_paid", int'(paid_units), e.paid);
                    chk("done_cnt5", int'(cnt5), e.c5);
                    chk("done_cnt10", int'(cnt10), e.c10);
                end
            end
        end
    end

    // Issue one request; drops assumed at C2+3i with immediate hop_done.
    task automatic run_req(input int amount, input int ndrops, input bit [15:0] ten_mask,
                           input int done_off, input bit sh, input int paid,
                           input int c5, input int c10, input int r5_at);
        int base;
        drop_t d;
        done_t e;
        @(negedge clk);
        base = cyc;
        for (int i = 0; i < ndrops; i++) begin
            d.cyc  = base + 2 + 3 * i;
            d.is10 = ten_mask[i];
            drop_q.push_back(d);
        end
        e.cyc = base + done_off; e.sh = sh; e.paid = paid; e.c5 = c5; e.c10 = c10;
        done_q.push_back(e);
        req_valid  = 1'b1;
        req_amount = 4'(amount);
        refill5    = (r5_at == 0);
        for (int k = 1; k <= done_off + 2; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            refill5   = (k == r5_at);
        end
        refill5 = 1'b0;
        chk("drop_q_drained", drop_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("idle_ready", int'(req_ready), 1);
        chk("idle_cnt5", int'(cnt5), c5);
        chk("idle_cnt10", int'(cnt10), c10);
        chk("idle_paid_hold", int'(paid_units), paid);
    endtask

    task automatic idle_refill(input bit r5, input bit r10, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            refill5  = r5;
            refill10 = r10;
        end
        @(negedge clk);
        refill5  = 1'b0;
        refill10 = 1'b0;
    endtask

    initial begin
        int base;
        drop_t d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_drop5", int'(drop5), 0);
        chk("rst_drop10", int'(drop10), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_paid", int'(paid_units), 0);
        chk("rst_cnt5", int'(cnt5), 8);
        chk("rst_cnt10", int'(cnt10), 8);
        rst = 1'b0;

        // amount 3: ten at C2, five at C5, done C8
        run_req(3, 2, 16'b01, 8, 1'b0, 3, 7, 7, -1);
        // amount 0: done C2, no drop
        run_req(0, 0, 16'b0, 2, 1'b0, 0, 7, 7, -1);
        // refill5 in the drop5 cycle leaves cnt5 at 7
        run_req(1, 1, 16'b0, 5, 1'b0, 1, 7, 7, 2);
        // drain all tens: 7 tens, done C23
        run_req(14, 7, 16'h007F, 23, 1'b0, 14, 7, 0, -1);
        // no tens left: two fives, done C8
        run_req(2, 2, 16'b0, 8, 1'b0, 2, 5, 0, -1);
        // drain all fives
        run_req(5, 5, 16'b0, 17, 1'b0, 5, 0, 0, -1);
        idle_refill(1'b0, 1'b1, 2);
        chk("refill10_twice", int'(cnt10), 2);
        // no fives: one ten then short, done C5
        run_req(3, 1, 16'b1, 5, 1'b1, 2, 0, 1, -1);

        // saturation: 1 + 260 refills clamps at 255
        idle_refill(1'b0, 1'b1, 260);
        chk("cnt10_saturate", int'(cnt10), 255);
        idle_refill(1'b0, 1'b1, 3);
        chk("cnt10_saturate_hold", int'(cnt10), 255);

        // reset during WAIT of a 3-unit request
        @(negedge clk);
        base = cyc;
        d.cyc = base + 2; d.is10 = 1'b1;
        drop_q.push_back(d);
        req_valid = 1'b1; req_amount = 4'd3;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_cnt10_dec", int'(cnt10), 254);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", int'(req_ready), 1);
        chk("midrst_drop10", int'(drop10), 0);
        chk("midrst_drop5", int'(drop5), 0);
        chk("midrst_cnt5", int'(cnt5), 8);
        chk("midrst_cnt10", int'(cnt10), 8);
        chk("midrst_paid", int'(paid_units), 0);
        repeat (10) @(negedge clk);
        chk("midrst_drop_q", drop_q.size(), 0);

        // hopper timeout: 16 WAIT cycles C3..C18, FAULT in C19
        hop_done = 1'b0;
        @(negedge clk);
        base = cyc;
        d.cyc = base + 2; d.is10 = 1'b1;
        drop_q.push_back(d);
        req_valid = 1'b1; req_amount = 4'd3;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("fault_not_yet", int'(fault), 0);
        @(negedge clk);
        chk("fault_cycle", cyc - base, 19);
        chk("fault_set", int'(fault), 1);
        chk("fault_ready", int'(req_ready), 0);
        req_valid = 1'b1; req_amount = 4'd2; refill5 = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; refill5 = 1'b0;
        repeat (5) @(negedge clk);
        chk("fault_sticky", int'(fault), 1);
        chk("fault_ready_low", int'(req_ready), 0);
        chk("fault_refill5", int'(cnt5), 9);
        chk("fault_cnt10", int'(cnt10), 7);
        chk("fault_paid", int'(paid_units), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hop_done = 1'b1;
        chk("fault_rst_clear", int'(fault), 0);
        chk("fault_rst_ready", int'(req_ready), 1);
        chk("fault_rst_cnt5", int'(cnt5), 8);
        chk("fault_rst_cnt10", int'(cnt10), 8);

        // still operational after fault recovery
        run_req(2, 1, 16'b1, 5, 1'b0, 2, 8, 7, -1);
        chk("end_drop_q", drop_q.size(), 0);
        chk("end_done_q", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
